// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Optional almost-full output is enabled by defining FIFO_WPTR_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH = 3
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_LEVEL   = 6
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RQ2_RPTR,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR,
  output logic                  FULL
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  ,
  output logic                  ALMOST_FULL
`endif
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic          wr_en_c;

  // Next pointer in binary and Gray; full when the next Gray pointer is one lap ahead of the read pointer
  always_comb begin
    wr_en_c = W_INC & ~full_q;
    wbin_d  = wbin_q + PW'(wr_en_c);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    full_d  = (wgray_d == {~RQ2_RPTR[ADDR_WIDTH:ADDR_WIDTH-1], RQ2_RPTR[ADDR_WIDTH-2:0]});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  assign W_ADDR = wbin_q[ADDR_WIDTH-1:0];
  assign W_PTR  = wgray_q;
  assign FULL   = full_q;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  logic [PW-1:0] rbin_c;
  logic [PW-1:0] fill_c;
  logic          afull_q, afull_d;

  // Gray-to-binary of the synchronized read pointer, then next fill level
  always_comb begin
    rbin_c[ADDR_WIDTH] = RQ2_RPTR[ADDR_WIDTH];
    for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
      rbin_c[i] = rbin_c[i+1] ^ RQ2_RPTR[i];
    end
    fill_c  = wbin_d - rbin_c;
    afull_d = (fill_c >= PW'(AF_LEVEL));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign ALMOST_FULL = afull_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDR_WIDTH=3); checks ALMOST_FULL when FIFO_WPTR_ALMOST_FULL_EN is defined.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_inc;
  logic [3:0] rq2_rptr;
  logic [2:0] w_addr;
  logic [3:0] w_ptr;
  logic       full;
  logic       almost_full;

  always #5 clk = ~clk;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  fifo_wptr_full #(.ADDR_WIDTH(3), .AF_LEVEL(6)) dut (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .RQ2_RPTR(rq2_rptr),
    .W_ADDR(w_addr), .W_PTR(w_ptr), .FULL(full), .ALMOST_FULL(almost_full)
  );
`else
  fifo_wptr_full #(.ADDR_WIDTH(3)) dut (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .RQ2_RPTR(rq2_rptr),
    .W_ADDR(w_addr), .W_PTR(w_ptr), .FULL(full)
  );
  assign almost_full = 1'b0;
`endif

  typedef struct {
    logic [2:0] addr;
    logic [3:0] ptr;
    logic       full;
    logic       af;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] m_wbin = '0;
  logic       m_full = 1'b0;
  logic [3:0] m_rbin = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] ungray(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle, predict via occupancy, then compare after the edge
  task automatic step(input logic inc, input logic [3:0] rptr, input logic r);
    exp_t e;
    exp_t o;
    logic [3:0] nb;
    logic [3:0] occ;
    @(negedge clk);
    w_inc    = inc;
    rq2_rptr = rptr;
    rst      = r;
    if (r) begin
      m_wbin = '0;
      m_full = 1'b0;
      e.af   = 1'b0;
    end else begin
      nb     = m_wbin + {3'b000, (inc & ~m_full)};
      occ    = nb - ungray(rptr);
      m_wbin = nb;
      m_full = (occ == 4'd8);
      e.af   = (occ >= 4'd6);
    end
    e.addr = m_wbin[2:0];
    e.ptr  = gray(m_wbin);
    e.full = m_full;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      o = exp_q.pop_front();
      chk("w_addr", 32'(w_addr), 32'(o.addr));
      chk("w_ptr", 32'(w_ptr), 32'(o.ptr));
      chk("full", 32'(full), 32'(o.full));
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      chk("almost_full", 32'(almost_full), 32'(o.af));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; w_inc = 1'b1; rq2_rptr = '0;

    // Reset with W_INC asserted
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("reset_ptr", 32'(w_ptr), 32'h0);

    // Fill to full, then writes while full are ignored
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 1'b0);
    chk("fill_ptr", 32'(w_ptr), 32'hC);
    chk("fill_full", 32'(full), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b0);
    chk("held_ptr", 32'(w_ptr), 32'hC);
    chk("held_addr", 32'(w_addr), 32'h0);

    // Release by one read, refill by one write
    step(1'b0, 4'b0001, 1'b0);
    chk("release_full", 32'(full), 32'h0);
    step(1'b1, 4'b0001, 1'b0);
    chk("refill_ptr", 32'(w_ptr), 32'hD);
    chk("refill_full", 32'(full), 32'h1);

    // Wrap with read pointer tracking the writes
    step(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, gray(m_wbin), 1'b0);
    chk("wrap_ptr", 32'(w_ptr), 32'h0);
    chk("wrap_full", 32'(full), 32'h0);

    // Reset mid-sequence at W_PTR=0110
    for (int i = 0; i < 4; i++) step(1'b1, gray(m_wbin), 1'b0);
    chk("mid_ptr", 32'(w_ptr), 32'h6);
    step(1'b1, w_ptr, 1'b1);
    chk("mid_rst_ptr", 32'(w_ptr), 32'h0);

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    // Almost-full threshold at 6 entries
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 1'b0);
    chk("af_5", 32'(almost_full), 32'h0);
    step(1'b1, 4'b0000, 1'b0);
    chk("af_6", 32'(almost_full), 32'h1);
    step(1'b0, 4'b0001, 1'b0);
    chk("af_release", 32'(almost_full), 32'h0);
    step(1'b0, 4'b0000, 1'b1);
`endif

    // Random writes and one-step read-pointer advances
    m_rbin = '0;
    for (int i = 0; i < 200; i++) begin
      if (m_rbin != m_wbin && $urandom_range(0, 2) == 0) m_rbin = m_rbin + 4'd1;
      step(1'($urandom_range(0, 3) != 0), gray(m_rbin), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
